// File: rtl/nand4_pkg.sv
// Shared constants and types for the 4-input NAND switch-level cell.
package nand4_pkg;

    localparam int unsigned N_IN   = 4;
    localparam int unsigned N_NODE = 3;

    localparam int unsigned IDX_A = 0;
    localparam int unsigned IDX_B = 1;
    localparam int unsigned IDX_C = 2;
    localparam int unsigned IDX_D = 3;

    localparam int unsigned W9 = 0;
    localparam int unsigned W8 = 1;
    localparam int unsigned W7 = 2;

    typedef logic [N_IN-1:0]   nand_in_t;
    typedef logic [N_NODE-1:0] node_t;

    typedef enum logic {
        MOS_PMOS = 1'b0,
        MOS_NMOS = 1'b1
    } mos_kind_t;

    function automatic logic nand_eval(input nand_in_t x);
        return ~&x;
    endfunction

endpackage

// File: rtl/mos_switch.sv
// Single transistor conduction evaluator: PMOS conducts on a low gate, NMOS on a high gate.
module mos_switch
    import nand4_pkg::*;
#(
    parameter mos_kind_t KIND = MOS_NMOS
) (
    input  logic gate,
    output logic conduct
);

    assign conduct = (KIND == MOS_PMOS) ? ~gate : gate;

endmodule

// File: rtl/nand4_switch_cell.sv
// Cycle-accurate model of a static CMOS NAND4 with built-in binary pattern generator
// and a sticky self-check on the gate output.
module nand4_switch_cell
    import nand4_pkg::*;
#(
    parameter logic GEN_DEFAULT = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     gen_sel,
    input  nand_in_t ext_in,
    output nand_in_t pattern,
    output logic     out1,
    output nand_in_t pu_on,
    output nand_in_t pd_on,
    output node_t    node_low,
    output logic     err
);

    logic     use_gen;
    nand_in_t gin;
    nand_in_t pu_c;
    nand_in_t pd_c;
    logic     w9_c;
    logic     w8_c;
    logic     w7_c;
    nand_in_t gin_q;
    logic     chk_vld;
    logic     mismatch_c;

    // Source select falls back to the reset default while rst is asserted.
    always_comb begin
        use_gen = gen_sel;
        if (rst) begin
            use_gen = GEN_DEFAULT;
        end
        gin = use_gen ? pattern : ext_in;
    end

    for (genvar k = 0; k < N_IN; k++) begin : g_dev
        mos_switch #(.KIND(MOS_PMOS)) u_pmos (
            .gate    (gin[k]),
            .conduct (pu_c[k])
        );
        mos_switch #(.KIND(MOS_NMOS)) u_nmos (
            .gate    (gin[k]),
            .conduct (pd_c[k])
        );
    end

    // Stack nodes are pulled to vss through the contiguous conducting NMOS chain from D upward.
    always_comb begin
        w9_c = pd_c[IDX_D];
        w8_c = pd_c[IDX_C] & w9_c;
        w7_c = pd_c[IDX_B] & w8_c;
    end

    // Output must match NAND of last gin, and exactly one network must be active.
    always_comb begin
        mismatch_c = 1'b0;
        if (chk_vld) begin
            mismatch_c = (out1 != nand_eval(gin_q))
                       | ~((|pu_on) ^ (&pd_on))
                       | (out1 != (|pu_on));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern  <= '0;
            out1     <= 1'b1;
            pu_on    <= '1;
            pd_on    <= '0;
            node_low <= '0;
            err      <= 1'b0;
            gin_q    <= '0;
            chk_vld  <= 1'b0;
        end else begin
            if (en) begin
                pattern <= pattern + N_IN'(1);
            end
            out1         <= |pu_c;
            pu_on        <= pu_c;
            pd_on        <= pd_c;
            node_low[W9] <= w9_c;
            node_low[W8] <= w8_c;
            node_low[W7] <= w7_c;
            gin_q        <= gin;
            chk_vld      <= 1'b1;
            if (mismatch_c) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nand4_switch_cell.sv
// Scoreboard bench for nand4_switch_cell: reference model predicts each cycle's outputs.
module tb_nand4_switch_cell;

    logic       clk;
    logic       rst;
    logic       en;
    logic       gen_sel;
    logic [3:0] ext_in;
    logic [3:0] pattern;
    logic       out1;
    logic [3:0] pu_on;
    logic [3:0] pd_on;
    logic [2:0] node_low;
    logic       err;

    typedef struct packed {
        logic       out1;
        logic [3:0] pu;
        logic [3:0] pd;
        logic [2:0] node;
        logic [3:0] pat;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] m_pat;
    int         n_checks;
    int         n_errors;

    nand4_switch_cell #(.GEN_DEFAULT(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .gen_sel  (gen_sel),
        .ext_in   (ext_in),
        .pattern  (pattern),
        .out1     (out1),
        .pu_on    (pu_on),
        .pd_on    (pd_on),
        .node_low (node_low),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input logic r, input logic e, input logic g, input logic [3:0] x);
        exp_t       ex;
        exp_t       got;
        logic [3:0] gi;
        rst     = r;
        en      = e;
        gen_sel = g;
        ext_in  = x;
        if (r) begin
            ex    = '{out1: 1'b1, pu: 4'hF, pd: 4'h0, node: 3'b000, pat: 4'h0};
            m_pat = 4'h0;
        end else begin
            gi      = g ? m_pat : x;
            ex.out1 = ~(gi[0] & gi[1] & gi[2] & gi[3]);
            ex.pu   = ~gi;
            ex.pd   = gi;
            ex.node = {gi[1] & gi[2] & gi[3], gi[2] & gi[3], gi[3]};
            if (e) m_pat = m_pat + 4'd1;
            ex.pat  = m_pat;
        end
        sb_q.push_back(ex);
        @(posedge clk);
        @(negedge clk);
        got = sb_q.pop_front();
        check("out1", 32'(out1), 32'(got.out1));
        check("pu_on", 32'(pu_on), 32'(got.pu));
        check("pd_on", 32'(pd_on), 32'(got.pd));
        check("node_low", 32'(node_low), 32'(got.node));
        check("pattern", 32'(pattern), 32'(got.pat));
        check("err", 32'(err), 32'd0);
        check("pu_xor_pd", 32'((|pu_on) ^ (&pd_on)), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_pat    = 4'h0;
        rst      = 1'b1;
        en       = 1'b0;
        gen_sel  = 1'b1;
        ext_in   = 4'h0;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b1, 4'h0);

        // Generator sweep through wrap.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 4'h0);
        check("wrap_pattern", 32'(pattern), 32'h0);
        check("wrap_out1_low", 32'(out1), 32'd0);

        // External corner patterns.
        step(1'b0, 1'b0, 1'b0, 4'hF);
        check("allone_node", 32'(node_low), 32'h7);
        step(1'b0, 1'b0, 1'b0, 4'hE);
        check("a_low_pu", 32'(pu_on), 32'h1);
        step(1'b0, 1'b0, 1'b0, 4'h7);
        check("d_low_node", 32'(node_low), 32'h0);

        // Advance to 6 then hold with en low.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 4'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 4'h0);
        check("hold_pattern", 32'(pattern), 32'h6);
        check("hold_out1", 32'(out1), 32'd1);

        step(1'b1, 1'b1, 1'b1, 4'hF);

        // All external values back-to-back while the generator keeps running.
        for (int v = 0; v < 16; v++) step(1'b0, 1'b1, 1'b0, 4'(v));

        // Random mix including mid-sequence resets.
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
